remainder_right_shifter: RTL

Multi-cycle parametrized right shifter for the divider datapath: the inverse of the normalization left shift. After division completes, it shifts the normalized partial remainder back right by the accumulated normalization count. It moves at most 7 positions per cycle, matching the 3-bit per-cycle shift of the normalization path. It supports logical and arithmetic (sign-extending) modes, produces a sticky bit for bits lost off the LSB end, and reports completion with a start/busy/done handshake.

---
 rtl/remainder_right_shifter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/remainder_right_shifter.sv
// ---------------------------------------------------------------------------
// remainder_right_shifter
//
// Multi-cycle right shifter that undoes the divider's normalization left
// shift. The captured value moves right by at most 7 positions per clock
// until the full count has been applied. Supports logical (zero fill) and
// arithmetic (sign fill) modes and accumulates a sticky bit for every 1-bit
// that falls off the LSB end.
//
// Parameters
//   WIDTH      datapath width in bits
//   CNT_WIDTH  width of the total shift count (must be >= 3)
//
// Ports
//   clk        system clock, rising edge
//   rst_b      synchronous reset, active-high (despite the name)
//   start      request pulse, sampled only while idle
//   arith      1 = arithmetic shift, 0 = logical; captured with start
//   shift_amt  total right-shift count; captured with start
//   in         value to shift; captured with start
//   out        working / result register
//   sticky     OR of all bits shifted out during the current operation
//   busy       high while shifting and during the done cycle
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
module remainder_right_shifter #(
  parameter int WIDTH     = 17,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic                 arith,
  input  logic [CNT_WIDTH-1:0] shift_amt,
  input  logic [WIDTH-1:0]     in,
  output logic [WIDTH-1:0]     out,
  output logic                 sticky,
  output logic                 busy,
  output logic                 done
);

  // Largest per-cycle step; matches the 3-bit step of the normalizer.
  localparam int                 MAX_STEP = 7;
  localparam logic [CNT_WIDTH-1:0] STEP   = CNT_WIDTH'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_reg,  state_next;
  logic [WIDTH-1:0]     out_reg,    out_next;
  logic                 sticky_reg, sticky_next;
  logic [CNT_WIDTH-1:0] rem_reg,    rem_next;
  logic                 fill_reg,   fill_next;
  logic                 busy_reg;
  logic                 done_reg;

  // Per-cycle chunk: k = min(rem, 7)
  logic [CNT_WIDTH-1:0] k_wide;
  logic [2:0]           k;
  logic [CNT_WIDTH-1:0] rem_after;

  assign k_wide    = (rem_reg > STEP) ? STEP : rem_reg;
  assign k         = k_wide[2:0];
  assign rem_after = rem_reg - k_wide;

  // All eight candidate results of one step, plus the OR of the bits each
  // candidate would drop. Prepending the latched fill bit and doing a
  // signed shift fills the vacated MSBs with that bit for every amount.
  logic [WIDTH-1:0] shift_opt [0:MAX_STEP];
  logic             lost_opt  [0:MAX_STEP];

  generate
    for (genvar gi = 0; gi <= MAX_STEP; gi++) begin : g_step
      // Low gi bits of the working value; saturates to all ones if gi
      // ever exceeds the datapath width.
      localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << gi) - 64'd1);

      assign shift_opt[gi] = WIDTH'($signed({fill_reg, out_reg}) >>> gi);
      assign lost_opt[gi]  = |(out_reg & LOW_MASK);
    end
  endgenerate

  // Next-state and datapath update
  always_comb begin
    state_next  = state_reg;
    out_next    = out_reg;
    sticky_next = sticky_reg;
    rem_next    = rem_reg;
    fill_next   = fill_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          out_next    = in;
          sticky_next = 1'b0;
          rem_next    = shift_amt;
          // Fill bit is fixed at capture; every chunk reuses it.
          fill_next   = arith & in[WIDTH-1];
          state_next  = (shift_amt == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        out_next    = shift_opt[k];
        sticky_next = sticky_reg | lost_opt[k];
        rem_next    = rem_after;
        if (rem_after == '0) begin
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers. busy/done are registered from the next state so the
  // outputs carry no decode logic.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_reg  <= IDLE;
      out_reg    <= '0;
      sticky_reg <= 1'b0;
      rem_reg    <= '0;
      fill_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      out_reg    <= out_next;
      sticky_reg <= sticky_next;
      rem_reg    <= rem_next;
      fill_reg   <= fill_next;
      busy_reg   <= (state_next != IDLE);
      done_reg   <= (state_next == DONE);
    end
  end

  assign out    = out_reg;
  assign sticky = sticky_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule
